// File: rtl/cafetera_control_fsm.sv
// -----------------------------------------------------------------------------
// cafetera_control_fsm
//
// Sequencing controller for the coffee vending datapath. It edge-detects coin,
// product-selection and cancel inputs and keeps the coin credit. It checks the
// credit against the product price, times the dispense phase and returns change.
// It also drives the product/accept LEDs and the display-source select, and
// supplies the credit and price values to the display encoders.
//
// Ports:
//   clk                  in   1         system clock, rising edge
//   rst                  in   1         asynchronous active-high reset
//   Monedas              in   4         coin sensors (level, rising edge = coin)
//   seleccionador_4bits  in   4         product buttons (level, rising edge = request)
//   cancel               in   1         cancel button (level, rising edge = abort)
//   credit               out  CREDIT_W  accumulated credit
//   price                out  CREDIT_W  price of last selected product
//   change               out  CREDIT_W  last returned change, held
//   change_valid         out  1         one-clock pulse when change is issued
//   coin_reject          out  1         one-clock pulse when a coin is refused
//   LEDS_Seleccion       out  5         [3:0] one-hot product dispensing, [4] busy
//   LEDS_Aceptada        out  1         high while dispensing
//   display_sel          out  1         0 = show credit, 1 = show price
// -----------------------------------------------------------------------------
module cafetera_control_fsm #(
    parameter int CREDIT_W          = 8,
    parameter int COIN0_VAL         = 1,
    parameter int COIN1_VAL         = 2,
    parameter int COIN2_VAL         = 5,
    parameter int COIN3_VAL         = 10,
    parameter int PRICE0            = 6,
    parameter int PRICE1            = 8,
    parameter int PRICE2            = 10,
    parameter int PRICE3            = 12,
    parameter int MAX_CREDIT        = 99,
    parameter int DISPENSE_CYCLES   = 8,
    parameter int PRICE_SHOW_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          Monedas,
    input  logic [3:0]          seleccionador_4bits,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic [4:0]          LEDS_Seleccion,
    output logic                LEDS_Aceptada,
    output logic                display_sel
);

    localparam int DCNT_W = $clog2(DISPENSE_CYCLES + 1);
    localparam int SCNT_W = $clog2(PRICE_SHOW_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    // Credit units for a one-hot coin event.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] oh);
        logic [CREDIT_W-1:0] v;
        v = '0;
        case (oh)
            4'b0001: v = CREDIT_W'(COIN0_VAL);
            4'b0010: v = CREDIT_W'(COIN1_VAL);
            4'b0100: v = CREDIT_W'(COIN2_VAL);
            4'b1000: v = CREDIT_W'(COIN3_VAL);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Price of a one-hot product request.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [3:0] oh);
        logic [CREDIT_W-1:0] p;
        p = '0;
        case (oh)
            4'b0001: p = CREDIT_W'(PRICE0);
            4'b0010: p = CREDIT_W'(PRICE1);
            4'b0100: p = CREDIT_W'(PRICE2);
            4'b1000: p = CREDIT_W'(PRICE3);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Ceiling check done one bit wider so the sum can never wrap.
    function automatic logic credit_fits(input logic [CREDIT_W:0] sum);
        return (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    state_t              r_state;
    logic [3:0]          r_mon_q;
    logic [3:0]          r_sel_q;
    logic                r_can_q;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [CREDIT_W-1:0] r_change;
    logic                r_change_valid;
    logic                r_coin_reject;
    logic [4:0]          r_leds_sel;
    logic                r_leds_acc;
    logic                r_disp_sel;
    logic [DCNT_W-1:0]   r_disp_cnt;
    logic [SCNT_W-1:0]   r_show_cnt;

    logic [3:0]          w_coin_ev;
    logic [3:0]          w_sel_ev;
    logic                w_can_ev;
    logic                w_coin_any;
    logic                w_coin_one;
    logic                w_sel_valid;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [CREDIT_W:0]   w_sum;
    logic                w_can_buy;

    // Rising-edge events; edge registers reset to ones so a level held through
    // reset does not register as a fresh press.
    assign w_coin_ev   = Monedas & ~r_mon_q;
    assign w_sel_ev    = seleccionador_4bits & ~r_sel_q;
    assign w_can_ev    = cancel & ~r_can_q;
    assign w_coin_any  = (w_coin_ev != 4'b0000);
    assign w_coin_one  = is_onehot4(w_coin_ev);
    assign w_sel_valid = is_onehot4(w_sel_ev);
    assign w_coin_val  = coin_value(w_coin_ev);
    assign w_sel_price = price_of(w_sel_ev);
    assign w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_can_buy   = (r_credit >= w_sel_price);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mon_q        <= 4'b1111;
            r_sel_q        <= 4'b1111;
            r_can_q        <= 1'b1;
            r_credit       <= '0;
            r_price        <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_leds_sel     <= '0;
            r_leds_acc     <= 1'b0;
            r_disp_sel     <= 1'b0;
            r_disp_cnt     <= '0;
            r_show_cnt     <= '0;
        end else begin
            r_mon_q        <= Monedas;
            r_sel_q        <= seleccionador_4bits;
            r_can_q        <= cancel;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;

            // Price-show countdown; display_sel drops on the clock the count
            // reaches zero. Branches below may override (restart or clear).
            if (r_show_cnt != '0) begin
                r_show_cnt <= r_show_cnt - 1'b1;
                r_disp_sel <= (r_show_cnt > SCNT_W'(1));
            end

            case (r_state)
                S_IDLE, S_CREDIT: begin
                    if ((r_state == S_CREDIT) && w_can_ev) begin
                        // Abort: return the whole credit via CHANGE.
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_credit       <= '0;
                        r_state        <= S_CHANGE;
                        r_coin_reject  <= w_coin_any;
                    end else if (w_sel_valid) begin
                        r_price       <= w_sel_price;
                        r_coin_reject <= w_coin_any;
                        if (w_can_buy) begin
                            r_credit   <= r_credit - w_sel_price;
                            r_leds_sel <= {1'b1, w_sel_ev};
                            r_leds_acc <= 1'b1;
                            r_disp_cnt <= DCNT_W'(DISPENSE_CYCLES);
                            r_disp_sel <= 1'b0;
                            r_show_cnt <= '0;
                            r_state    <= S_DISPENSE;
                        end else begin
                            // Short credit: show the price for a while.
                            r_disp_sel <= 1'b1;
                            r_show_cnt <= SCNT_W'(PRICE_SHOW_CYCLES);
                        end
                    end else if (w_coin_any) begin
                        r_disp_sel <= 1'b0;
                        r_show_cnt <= '0;
                        if (w_coin_one && credit_fits(w_sum)) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_state  <= S_CREDIT;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end

                S_DISPENSE: begin
                    r_coin_reject <= w_coin_any;
                    if (r_disp_cnt == DCNT_W'(1)) begin
                        r_leds_sel <= '0;
                        r_leds_acc <= 1'b0;
                        r_disp_cnt <= '0;
                        if (r_credit != '0) begin
                            r_change       <= r_credit;
                            r_change_valid <= 1'b1;
                            r_credit       <= '0;
                            r_state        <= S_CHANGE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_disp_cnt <= r_disp_cnt - 1'b1;
                    end
                end

                S_CHANGE: begin
                    // change/change_valid were issued on entry; this cycle
                    // only refuses coins and returns to IDLE.
                    r_coin_reject <= w_coin_any;
                    r_state       <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign credit         = r_credit;
    assign price          = r_price;
    assign change         = r_change;
    assign change_valid   = r_change_valid;
    assign coin_reject    = r_coin_reject;
    assign LEDS_Seleccion = r_leds_sel;
    assign LEDS_Aceptada  = r_leds_acc;
    assign display_sel    = r_disp_sel;

endmodule

// File: tb/tb_cafetera_control_fsm.sv
module tb_cafetera_control_fsm;

    localparam int SIG_CREDIT = 0;
    localparam int SIG_PRICE  = 1;
    localparam int SIG_CHANGE = 2;
    localparam int SIG_CV     = 3;
    localparam int SIG_CR     = 4;
    localparam int SIG_LSEL   = 5;
    localparam int SIG_LACC   = 6;
    localparam int SIG_DSEL   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Monedas;
    logic [3:0] seleccionador_4bits;
    logic       cancel;
    logic [7:0] credit;
    logic [7:0] price;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic [4:0] LEDS_Seleccion;
    logic       LEDS_Aceptada;
    logic       display_sel;

    cafetera_control_fsm dut (
        .clk                 (clk),
        .rst                 (rst),
        .Monedas             (Monedas),
        .seleccionador_4bits (seleccionador_4bits),
        .cancel              (cancel),
        .credit              (credit),
        .price               (price),
        .change              (change),
        .change_valid        (change_valid),
        .coin_reject         (coin_reject),
        .LEDS_Seleccion      (LEDS_Seleccion),
        .LEDS_Aceptada       (LEDS_Aceptada),
        .display_sel         (display_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observe(input int sig);
        logic [31:0] o;
        case (sig)
            SIG_CREDIT: o = {24'b0, credit};
            SIG_PRICE:  o = {24'b0, price};
            SIG_CHANGE: o = {24'b0, change};
            SIG_CV:     o = {31'b0, change_valid};
            SIG_CR:     o = {31'b0, coin_reject};
            SIG_LSEL:   o = {27'b0, LEDS_Seleccion};
            SIG_LACC:   o = {31'b0, LEDS_Aceptada};
            SIG_DSEL:   o = {31'b0, display_sel};
            default:    o = 32'hdead_beef;
        endcase
        return o;
    endfunction

    task automatic expect_out(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sig);
            n_cmp++;
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock and compare everything queued for this step.
    task automatic cycle();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic press(input logic [3:0] m, input logic [3:0] s, input logic c);
        Monedas             = m;
        seleccionador_4bits = s;
        cancel              = c;
        cycle();
        Monedas             = 4'b0;
        seleccionador_4bits = 4'b0;
        cancel              = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        Monedas             = 4'b0;
        seleccionador_4bits = 4'b0;
        cancel              = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("rst_credit", SIG_CREDIT, 0);
        expect_out("rst_price",  SIG_PRICE,  0);
        expect_out("rst_change", SIG_CHANGE, 0);
        expect_out("rst_cv",     SIG_CV,     0);
        expect_out("rst_cr",     SIG_CR,     0);
        expect_out("rst_lsel",   SIG_LSEL,   0);
        expect_out("rst_lacc",   SIG_LACC,   0);
        expect_out("rst_dsel",   SIG_DSEL,   0);
        drain();
        rst = 1'b0;
        cycle();

        // Buy product0 with 5+2, change 1
        expect_out("t1_c5", SIG_CREDIT, 5);
        press(4'b0100, 4'b0, 1'b0);
        cycle();
        expect_out("t1_c7", SIG_CREDIT, 7);
        press(4'b0010, 4'b0, 1'b0);
        cycle();
        expect_out("t1_credit", SIG_CREDIT, 1);
        expect_out("t1_lsel",   SIG_LSEL,   5'b10001);
        expect_out("t1_lacc",   SIG_LACC,   1);
        expect_out("t1_price",  SIG_PRICE,  6);
        press(4'b0, 4'b0001, 1'b0);
        for (int i = 1; i < 8; i++) begin
            expect_out("t1_lacc_hold", SIG_LACC, 1);
            expect_out("t1_cv_low",    SIG_CV,   0);
            cycle();
        end
        expect_out("t1_lacc_off", SIG_LACC,   0);
        expect_out("t1_lsel_off", SIG_LSEL,   0);
        expect_out("t1_cv",       SIG_CV,     1);
        expect_out("t1_change",   SIG_CHANGE, 1);
        expect_out("t1_credit0",  SIG_CREDIT, 0);
        cycle();
        expect_out("t1_cv_pulse", SIG_CV, 0);
        cycle();

        // Short credit shows the price
        expect_out("t2_c5", SIG_CREDIT, 5);
        press(4'b0100, 4'b0, 1'b0);
        cycle();
        expect_out("t2_price",  SIG_PRICE,  12);
        expect_out("t2_dsel",   SIG_DSEL,   1);
        expect_out("t2_credit", SIG_CREDIT, 5);
        expect_out("t2_lacc",   SIG_LACC,   0);
        press(4'b0, 4'b1000, 1'b0);
        for (int i = 1; i < 4; i++) begin
            expect_out("t2_dsel_hold", SIG_DSEL, 1);
            cycle();
        end
        expect_out("t2_dsel_off", SIG_DSEL,   0);
        expect_out("t2_credit5",  SIG_CREDIT, 5);
        cycle();
        expect_out("t2_dsel_again", SIG_DSEL, 1);
        press(4'b0, 4'b1000, 1'b0);
        expect_out("t2_dsel_still", SIG_DSEL, 1);
        cycle();
        expect_out("t2_dsel_coin", SIG_DSEL,   0);
        expect_out("t2_c6",        SIG_CREDIT, 6);
        press(4'b0001, 4'b0, 1'b0);
        cycle();
        expect_out("t2_cv",     SIG_CV,     1);
        expect_out("t2_change", SIG_CHANGE, 6);
        expect_out("t2_cred0",  SIG_CREDIT, 0);
        press(4'b0, 4'b0, 1'b1);
        cycle();

        // Credit ceiling and multi-coin refusal
        for (int i = 0; i < 9; i++) begin
            expect_out("t3_build", SIG_CREDIT, 32'(10 * (i + 1)));
            press(4'b1000, 4'b0, 1'b0);
            cycle();
        end
        expect_out("t3_c95", SIG_CREDIT, 95);
        press(4'b0100, 4'b0, 1'b0);
        cycle();
        expect_out("t3_cr_over", SIG_CR,     1);
        expect_out("t3_c95_kep", SIG_CREDIT, 95);
        press(4'b1000, 4'b0, 1'b0);
        expect_out("t3_cr_low",  SIG_CR,     0);
        cycle();
        expect_out("t3_c97", SIG_CREDIT, 97);
        expect_out("t3_cr0", SIG_CR,     0);
        press(4'b0010, 4'b0, 1'b0);
        cycle();
        expect_out("t3_cr_multi", SIG_CR,     1);
        expect_out("t3_c97_kep",  SIG_CREDIT, 97);
        press(4'b0011, 4'b0, 1'b0);
        expect_out("t3_cr_low2", SIG_CR, 0);
        cycle();
        expect_out("t3_change", SIG_CHANGE, 97);
        expect_out("t3_cv",     SIG_CV,     1);
        press(4'b0, 4'b0, 1'b1);
        cycle();

        // Interference during dispense
        expect_out("t4_c10", SIG_CREDIT, 10);
        press(4'b1000, 4'b0, 1'b0);
        cycle();
        expect_out("t4_credit", SIG_CREDIT, 2);
        expect_out("t4_lsel",   SIG_LSEL,   5'b10010);
        expect_out("t4_price",  SIG_PRICE,  8);
        press(4'b0, 4'b0010, 1'b0);
        expect_out("t4_e1", SIG_LACC, 1);
        cycle();
        expect_out("t4_cr",     SIG_CR,     1);
        expect_out("t4_cr_crd", SIG_CREDIT, 2);
        expect_out("t4_e2",     SIG_LACC,   1);
        press(4'b0001, 4'b0, 1'b0);
        expect_out("t4_cr_low", SIG_CR, 0);
        cycle();
        expect_out("t4_can_crd", SIG_CREDIT, 2);
        expect_out("t4_can_cv",  SIG_CV,     0);
        expect_out("t4_e4",      SIG_LACC,   1);
        press(4'b0, 4'b0, 1'b1);
        cycle();
        expect_out("t4_sel_lsel", SIG_LSEL,  5'b10010);
        expect_out("t4_sel_prc",  SIG_PRICE, 8);
        expect_out("t4_e6",       SIG_LACC,  1);
        press(4'b0, 4'b0100, 1'b0);
        expect_out("t4_e7", SIG_LACC, 1);
        cycle();
        expect_out("t4_e8_lacc", SIG_LACC,   0);
        expect_out("t4_e8_cv",   SIG_CV,     1);
        expect_out("t4_e8_chg",  SIG_CHANGE, 2);
        expect_out("t4_e8_crd",  SIG_CREDIT, 0);
        cycle();
        cycle();

        // Cancel beats selection and coin in the same cycle
        expect_out("t5_c5", SIG_CREDIT, 5);
        press(4'b0100, 4'b0, 1'b0);
        cycle();
        expect_out("t5_c7", SIG_CREDIT, 7);
        press(4'b0010, 4'b0, 1'b0);
        cycle();
        expect_out("t5_cv",     SIG_CV,     1);
        expect_out("t5_change", SIG_CHANGE, 7);
        expect_out("t5_cr",     SIG_CR,     1);
        expect_out("t5_credit", SIG_CREDIT, 0);
        expect_out("t5_lacc",   SIG_LACC,   0);
        press(4'b0010, 4'b0001, 1'b1);
        expect_out("t5_cv_low", SIG_CV,   0);
        expect_out("t5_cr_low", SIG_CR,   0);
        expect_out("t5_lacc2",  SIG_LACC, 0);
        cycle();
        cycle();

        // Reset in dispense cycle 3 with button held
        expect_out("t6_c10", SIG_CREDIT, 10);
        press(4'b1000, 4'b0, 1'b0);
        cycle();
        seleccionador_4bits = 4'b0010;
        expect_out("t6_lacc_on", SIG_LACC, 1);
        cycle();
        cycle();
        cycle();
        #3;
        rst = 1'b1;
        #1;
        expect_out("t6_rst_lacc", SIG_LACC,   0);
        expect_out("t6_rst_lsel", SIG_LSEL,   0);
        expect_out("t6_rst_crd",  SIG_CREDIT, 0);
        expect_out("t6_rst_cv",   SIG_CV,     0);
        expect_out("t6_rst_prc",  SIG_PRICE,  0);
        drain();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_out("t6_held_lacc", SIG_LACC,  0);
            expect_out("t6_held_dsel", SIG_DSEL,  0);
            expect_out("t6_held_prc",  SIG_PRICE, 0);
            expect_out("t6_held_cv",   SIG_CV,    0);
            cycle();
        end
        Monedas = 4'b1000;
        expect_out("t6_c10b",    SIG_CREDIT, 10);
        expect_out("t6_no_disp", SIG_LACC,   0);
        cycle();
        Monedas = 4'b0;
        expect_out("t6_no_disp2", SIG_LACC, 0);
        cycle();
        seleccionador_4bits = 4'b0;
        cycle();
        expect_out("t6_disp_lacc", SIG_LACC,   1);
        expect_out("t6_disp_crd",  SIG_CREDIT, 2);
        expect_out("t6_disp_lsel", SIG_LSEL,   5'b10010);
        press(4'b0, 4'b0010, 1'b0);
        for (int i = 1; i < 8; i++) begin
            expect_out("t6_lacc_hold", SIG_LACC, 1);
            cycle();
        end
        expect_out("t6_end_lacc", SIG_LACC,   0);
        expect_out("t6_end_cv",   SIG_CV,     1);
        expect_out("t6_end_chg",  SIG_CHANGE, 2);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
